// File: rtl/bus_defs.sv
// Shared definitions for the RAM data-port arbiter: widths, FSM encoding, master indices.
package bus_defs;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic M_CORE = 1'b0;
  localparam logic M_LOAD = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  function automatic state_t own_state(input logic idx);
    return (idx == M_LOAD) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector; a forced index wins when that master is requesting.
module rr_pick2
  import bus_defs::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       force_en,
  input  logic       force_idx,
  output logic       vld,
  output logic       idx
);

  always_comb begin
    idx = M_CORE;
    if (force_en && req[force_idx]) begin
      idx = force_idx;
    end else if (&req) begin
      idx = ~last;
    end else if (req[1]) begin
      idx = M_LOAD;
    end
  end

  assign vld = |req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the RAM data port between core LSU (m0) and loader/debug (m1): combinational grant,
// registered mem strobe one cycle later, read data tagged back to its master two cycles after grant.
module mem_bus_arbiter
  import bus_defs::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic                m0_lock,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic                m1_lock,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [7:0] WMAX = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic        last_q;
  logic        brk, brk_idx, brk_q, brk_idx_q;
  logic [7:0]  wcnt0_q, wcnt1_q;
  logic        pick_vld, pick_idx;
  logic        gnt0, gnt1, gnt_any;
  logic        rd1_q, tag1_q, rd2_q, tag2_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  // A broken lock hands the next selection to the waiter regardless of last_q.
  rr_pick2 u_pick (
    .req       ({m1_req, m0_req}),
    .last      (last_q),
    .force_en  (brk_q),
    .force_idx (brk_idx_q),
    .vld       (pick_vld),
    .idx       (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    brk     = 1'b0;
    brk_idx = M_CORE;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt0 = (pick_idx == M_CORE);
          gnt1 = (pick_idx == M_LOAD);
          if ((pick_idx == M_LOAD) ? m1_lock : m0_lock) state_d = own_state(pick_idx);
        end
      end
      OWN0: begin
        if (m1_req && wcnt1_q == WMAX) begin
          brk     = 1'b1;
          brk_idx = M_LOAD;
          state_d = IDLE;
        end else begin
          gnt0 = m0_req;
          if (!m0_lock) state_d = IDLE;
        end
      end
      OWN1: begin
        if (m0_req && wcnt0_q == WMAX) begin
          brk     = 1'b1;
          brk_idx = M_CORE;
          state_d = IDLE;
        end else begin
          gnt1 = m1_req;
          if (!m1_lock) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_any = gnt0 | gnt1;
  assign m0_gnt  = gnt0;
  assign m1_gnt  = gnt1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      last_q    <= M_LOAD;
      brk_q     <= 1'b0;
      brk_idx_q <= M_CORE;
      wcnt0_q   <= '0;
      wcnt1_q   <= '0;
    end else begin
      state_q   <= state_d;
      brk_q     <= brk;
      brk_idx_q <= brk_idx;
      if (gnt_any) last_q <= gnt1;
      // Waiting only counts while the other master holds the lock.
      if (gnt0) wcnt0_q <= '0;
      else if (m0_req && state_q == OWN1 && wcnt0_q != WMAX) wcnt0_q <= wcnt0_q + 8'd1;
      if (gnt1) wcnt1_q <= '0;
      else if (m1_req && state_q == OWN0 && wcnt1_q != WMAX) wcnt1_q <= wcnt1_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      rd1_q     <= 1'b0;
      tag1_q    <= M_CORE;
      rd2_q     <= 1'b0;
      tag2_q    <= M_CORE;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      mem_en <= gnt_any;
      if (gnt_any) begin
        mem_we    <= gnt1 ? m1_we    : m0_we;
        mem_addr  <= gnt1 ? m1_addr  : m0_addr;
        mem_wdata <= gnt1 ? m1_wdata : m0_wdata;
        mem_wmask <= gnt1 ? m1_wmask : m0_wmask;
      end
      rd1_q  <= gnt_any && !(gnt1 ? m1_we : m0_we);
      tag1_q <= gnt1;
      rd2_q  <= rd1_q;
      tag2_q <= tag1_q;
      if (m0_rvalid) rdata0_q <= mem_rdata;
      if (m1_rvalid) rdata1_q <= mem_rdata;
    end
  end

  // RAM data arrives in the cycle after mem_en, so it is forwarded combinationally and held after.
  assign m0_rvalid = rd2_q && (tag2_q == M_CORE);
  assign m1_rvalid = rd2_q && (tag2_q == M_LOAD);
  assign m0_rdata  = m0_rvalid ? mem_rdata : rdata0_q;
  assign m1_rdata  = m1_rvalid ? mem_rdata : rdata1_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single data port of the SoC dual-port RAM between two requesters: master 0 = core load/store unit, master 1 = program loader/debug port.
- Sits between `riscv` and the RAM data port inside `riscv_soc`.
- Registered round-robin arbitration with optional lock for multi-beat sequences and a starvation breaker.
- Tags the returned read data to the master that issued the read.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; a power of 2 and at least 8.
- MAX_WAIT, 8, cycles a requester may wait behind a locked owner before the lock is broken; range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- mN_req (N=0,1)  in  1  request valid, held until granted
- mN_we  in  1  1 = write, 0 = read
- mN_lock  in  1  keep ownership after this access
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  DATA_W  write data
- mN_wmask  in  DATA_W/8  byte-enable mask
- mN_gnt  out  1  access accepted this cycle
- mN_rvalid  out  1  read data valid
- mN_rdata  out  DATA_W  read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  DATA_W/8  memory byte-enable mask
- mem_rdata  in  DATA_W  read data, valid 1 cycle after mem_en with mem_we=0

Behaviour:
- Reset values: mem_en, mem_we, all gnt and rvalid = 0; mem_addr, mem_wdata, mem_wmask, rdata = 0; last_served = 1, so master 0 wins first; state = IDLE; wait counters = 0.
- States:
  - IDLE: no owner.
  - OWN0: master 0 holds the lock.
  - OWN1: master 1 holds the lock.
- Selection in IDLE:
  - Only one req → that master is selected.
  - Both req → the master ≠ last_served is selected.
  - Granted master has lock=1 → go to OWNx.
- In OWNx:
  - Only master x can be granted.
  - Grant occurs each cycle mx_req=1.
  - Return to IDLE on a granted access with mx_lock=0, or when mx_req=0 and mx_lock=0.
- mN_gnt is combinational in the cycle of acceptance. The master may change req/addr on the following cycle.
- Accepted access drives registered mem_* one cycle later: mem_en=1 for exactly that cycle, with captured we, addr, wdata, wmask. last_served updates to the granted master.
- Read latency from gnt to rvalid is 2 cycles:
  - gnt at cycle T.
  - mem_en at T+1.
  - mN_rvalid=1 at T+2 with mN_rdata = mem_rdata.
- Owner tag: a registered owner tag routes rvalid. The non-owner's rvalid stays 0 and its rdata holds its previous value.
- Writes produce no rvalid.
- Back-to-back accepted accesses sustain one per cycle.
- Starvation breaker:
  - Each master has a wait counter. It increments while the master requests, is not granted, and the other master owns the lock.
  - It saturates at MAX_WAIT and clears on grant.
  - On reaching MAX_WAIT, the FSM forces IDLE at the end of that cycle and the waiter wins the next selection regardless of last_served.
  - The broken owner sees gnt=0 for that cycle and must retry.
- Simultaneous events:
  - Lock release and other-request in the same cycle: the release completes; the other master may be granted the next cycle.
  - A req with both lock and a break in the same cycle: the break wins.
- Reset asserted mid-transaction: all in-flight reads are discarded, no rvalid is issued, and every output returns to its reset value asynchronously.
- Address/mask pass through unmodified. No alignment checking.

Decomposition:
- Shared package `bus_defs`:
  - ADDR_W/DATA_W defaults.
  - State encoding: IDLE=2'd0, OWN0=2'd1, OWN1=2'd2.
  - Master index constants M_CORE=0, M_LOAD=1.
- One natural sub-module: `rr_pick2`, the 2-way round-robin selector with a force input.
- Request muxing, FSM, counters and the response pipe stay in the top.

Test Plan:
- Single read: m0 read addr 0x100 with mem_rdata=0xDEADBEEF. Expect m0_gnt at T, mem_en at T+1, m0_rvalid=1 and m0_rdata=0xDEADBEEF at T+2, m1_rvalid=0 throughout.
- Contention: both masters request reads every cycle without lock after reset. Expect grants alternating m0, m1, m0, m1, with rvalid routed to the matching master 2 cycles after each grant.
- Lock burst: m1 does 4 locked writes to 0x0..0xC, last one lock=0, while m0 requests continuously. Expect 4 consecutive m1 grants, then an m0 grant on the next cycle; mem_wmask is passed through exactly.
- Starvation with MAX_WAIT=3: m1 holds lock indefinitely and m0 requests. Expect m0_gnt on the 5th cycle after m0_req rose (3 wait cycles, break, grant); m1 is not granted in that break cycle.
- Reset mid-read: assert rstn=0 one cycle after m0_gnt. Expect mem_en=0 and m0_rvalid=0 immediately; after release, a single m1 request is granted, not m0 by stale priority.
- Back-to-back mixed: m0 issues W 0x20=0x11223344, then R 0x20, on consecutive cycles. Expect mem_en for 2 consecutive cycles with we=1 then 0, and one rvalid only, for the read.
